// File: rtl/compact_if.sv
// compact_if: bundles the configuration, input-group and output-group
// signals of the compact stage.
//   configure + config fields : load a new run
//   data_in / valid_in / avail_out : upstream write side (avail_out from stage)
//   data_out / valid_out / avail_in : downstream side (avail_in from consumer)
// master modport drives the stage, slave modport is the stage itself.
interface compact_if #(
  parameter int GROUP_SIZE             = 8,
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_COLS           = 16
);
  logic                                configure;
  logic [LOG_MAX_ITERS-1:0]            num_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0]   num_reads_per_iter;
  logic [LOG_MAX_COLS-1:0]             cols_in;
  logic [LOG_MAX_COLS-1:0]             col_skip;
  logic [LOG_MAX_COLS-1:0]             cols_out;
  logic [2*LOG_MAX_COLS-1:0]           num_items;

  logic [GROUP_SIZE*DATA_WIDTH-1:0]    data_in;
  logic                                valid_in;
  logic                                avail_out;

  logic [GROUP_SIZE*DATA_WIDTH-1:0]    data_out;
  logic                                valid_out;
  logic                                avail_in;

  modport master (
    output configure, num_iters, num_reads_per_iter, cols_in, col_skip,
           cols_out, num_items, data_in, valid_in, avail_in,
    input  avail_out, data_out, valid_out
  );

  modport slave (
    input  configure, num_iters, num_reads_per_iter, cols_in, col_skip,
           cols_out, num_items, data_in, valid_in, avail_in,
    output avail_out, data_out, valid_out
  );
endinterface

// File: rtl/compact.sv
// compact: column-window compaction stage.
// Input groups of GROUP_SIZE items form row-major rows of cols_in items.
// Only columns [col_skip, col_skip+cols_out) of items below num_items are
// kept; kept items are repacked densely into output groups. At the end of
// each iteration a partial group is flushed with zero padding.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : compact_if.slave (config, input write side, output side)
module compact #(
  parameter int GROUP_SIZE             = 8,
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_COLS           = 16
) (
  input logic      clk,
  input logic      rst,
  compact_if.slave bus
);
  localparam int GW  = GROUP_SIZE * DATA_WIDTH;
  localparam int CW  = LOG_MAX_COLS;
  localparam int IW  = 2 * LOG_MAX_COLS;
  localparam int SN  = 2 * GROUP_SIZE;
  localparam int SIW = $clog2(SN);
  localparam int SCW = $clog2(SN + 1);
  localparam int RW  = LOG_MAX_READS_PER_ITER;
  localparam int NW  = LOG_MAX_ITERS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_END
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- FIFO
  logic [GW-1:0] fifo_mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    fifo_cnt;
  logic          fifo_wr, fifo_rd, fifo_empty, fifo_full, fifo_afull;
  logic [GW-1:0] head;

  assign fifo_empty    = (fifo_cnt == 3'd0);
  assign fifo_full     = (fifo_cnt == 3'd4);
  assign fifo_afull    = (fifo_cnt == 3'd3);
  // Dropping avail_out one slot early leaves one write of slack upstream.
  assign bus.avail_out = ~fifo_full & ~fifo_afull;
  assign fifo_wr       = bus.valid_in & ~fifo_full;
  assign head          = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 2'd1;
      if (fifo_rd) rd_ptr <= rd_ptr + 2'd1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ------------------------------------------------------- config / state
  logic [CW-1:0] cfg_cols_in, cfg_col_skip, cfg_cols_out;
  logic [IW-1:0] cfg_num_items;
  logic [RW-1:0] cfg_reads;
  logic [RW-1:0] reads_left;
  logic [NW-1:0] iters_left;
  logic [CW-1:0] col_base;
  logic [IW-1:0] item_idx;

  logic [DATA_WIDTH-1:0] stash [SN];
  logic [SCW-1:0]        stash_cnt;
  logic [GW-1:0]         data_q;
  logic                  valid_q;

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;

  // ---------------------------------------------------------- lane tagging
  logic [DATA_WIDTH-1:0] lane    [GROUP_SIZE];
  logic [CW:0]           col_raw [GROUP_SIZE];
  logic [CW-1:0]         col_tag [GROUP_SIZE];
  logic [IW:0]           idx_tag [GROUP_SIZE];
  logic [GROUP_SIZE-1:0] keep;
  logic [CW:0]           keep_hi;

  assign keep_hi = {1'b0, cfg_col_skip} + {1'b0, cfg_cols_out};

  // col_base < cols_in and cols_in >= GROUP_SIZE, so one subtraction
  // always brings the column back into range.
  always_comb begin
    for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
      lane[i]    = head[i*DATA_WIDTH +: DATA_WIDTH];
      col_raw[i] = {1'b0, col_base} + (CW+1)'(i);
      col_tag[i] = col_raw[i][CW-1:0];
      if (col_raw[i][CW] || (col_raw[i][CW-1:0] >= cfg_cols_in))
        col_tag[i] = col_raw[i][CW-1:0] - cfg_cols_in;
      idx_tag[i] = {1'b0, item_idx} + (IW+1)'(i);
      keep[i]    = (col_tag[i] >= cfg_col_skip) &&
                   ({1'b0, col_tag[i]} < keep_hi) &&
                   (idx_tag[i] < {1'b0, cfg_num_items});
    end
  end

  // ------------------------------------------------------------- append
  logic [DATA_WIDTH-1:0] app [SN];
  logic [SCW-1:0]        app_cnt, rem_cnt;
  logic                  emit_full;

  // stash_cnt < GROUP_SIZE between ops, so appending at most GROUP_SIZE
  // lanes never overruns the 2*GROUP_SIZE stash.
  always_comb begin
    app     = stash;
    app_cnt = stash_cnt;
    for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
      if (keep[i]) begin
        app[app_cnt[SIW-1:0]] = lane[i];
        app_cnt               = app_cnt + SCW'(1);
      end
    end
    emit_full = (app_cnt >= SCW'(GROUP_SIZE));
    rem_cnt   = emit_full ? (app_cnt - SCW'(GROUP_SIZE)) : app_cnt;
  end

  // Column/item advance for the next op.
  logic [CW:0]   col_sum;
  logic [CW-1:0] col_nxt;
  logic [IW:0]   idx_sum;
  logic [IW-1:0] idx_nxt;

  always_comb begin
    col_sum = {1'b0, col_base} + (CW+1)'(GROUP_SIZE);
    col_nxt = col_sum[CW-1:0];
    if (col_sum[CW] || (col_sum[CW-1:0] >= cfg_cols_in))
      col_nxt = col_sum[CW-1:0] - cfg_cols_in;
    idx_sum = {1'b0, item_idx} + (IW+1)'(GROUP_SIZE);
    idx_nxt = idx_sum[IW] ? '1 : idx_sum[IW-1:0];
  end

  // ----------------------------------------------------------------- FSM
  logic do_cfg, do_op, do_flush, last_read, last_iter;

  assign last_read = (reads_left == RW'(1));
  assign last_iter = (iters_left == NW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (do_cfg) state_nxt = S_RUN;
      S_RUN: begin
        if (do_cfg)
          state_nxt = S_RUN;
        else if (do_op && last_read)
          state_nxt = (rem_cnt != '0) ? S_FLUSH : S_END;
      end
      S_FLUSH: if (do_flush) state_nxt = S_END;
      S_END:   state_nxt = last_iter ? S_IDLE : S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // An op that coincides with configure still pops its group, but the
  // configure branch below takes priority so its items are discarded.
  always_comb begin
    do_cfg   = bus.configure && ((state == S_IDLE) || (state == S_RUN));
    do_op    = (state == S_RUN) && !fifo_empty && bus.avail_in;
    do_flush = (state == S_FLUSH) && bus.avail_in;
    fifo_rd  = do_op;
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_cols_in   <= '0;
      cfg_col_skip  <= '0;
      cfg_cols_out  <= '0;
      cfg_num_items <= '0;
      cfg_reads     <= '0;
      reads_left    <= '0;
      iters_left    <= '0;
      col_base      <= '0;
      item_idx      <= '0;
      stash_cnt     <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      for (int unsigned i = 0; i < SN; i++) stash[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      if (do_cfg) begin
        cfg_cols_in   <= bus.cols_in;
        cfg_col_skip  <= bus.col_skip;
        cfg_cols_out  <= bus.cols_out;
        cfg_num_items <= bus.num_items;
        cfg_reads     <= bus.num_reads_per_iter;
        reads_left    <= bus.num_reads_per_iter;
        iters_left    <= bus.num_iters;
        col_base      <= '0;
        item_idx      <= '0;
        stash_cnt     <= '0;
      end else if (do_op) begin
        if (emit_full) begin
          for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
            data_q[i*DATA_WIDTH +: DATA_WIDTH] <= app[i];
            stash[i]                           <= app[i+GROUP_SIZE];
            stash[i+GROUP_SIZE]                <= '0;
          end
          valid_q <= 1'b1;
        end else begin
          stash <= app;
        end
        stash_cnt <= rem_cnt;
        if (last_read) begin
          col_base   <= '0;
          item_idx   <= '0;
          reads_left <= cfg_reads;
        end else begin
          col_base   <= col_nxt;
          item_idx   <= idx_nxt;
          reads_left <= reads_left - RW'(1);
        end
      end else if (do_flush) begin
        for (int unsigned i = 0; i < GROUP_SIZE; i++)
          data_q[i*DATA_WIDTH +: DATA_WIDTH] <=
            (SCW'(i) < stash_cnt) ? stash[i] : '0;
        valid_q   <= 1'b1;
        stash_cnt <= '0;
      end else if ((state == S_END) && !last_iter) begin
        iters_left <= iters_left - NW'(1);
      end
    end
  end
endmodule

// File: tb/tb_compact.sv
module tb_compact;
  localparam int GS  = 4;
  localparam int DW  = 8;
  localparam int LMI = 16;
  localparam int LMR = 16;
  localparam int LMC = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  compact_if #(.GROUP_SIZE(GS), .DATA_WIDTH(DW), .LOG_MAX_ITERS(LMI),
               .LOG_MAX_READS_PER_ITER(LMR), .LOG_MAX_COLS(LMC)) bus ();

  compact #(.GROUP_SIZE(GS), .DATA_WIDTH(DW), .LOG_MAX_ITERS(LMI),
            .LOG_MAX_READS_PER_ITER(LMR), .LOG_MAX_COLS(LMC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] out_q [$];
  int          avail_viol = 0;
  int          ovf = 0;
  logic        avail_last = 1'b0;

  // Expected groups, item 0 in the low byte.
  logic [31:0] exp1 [4] = '{32'h07040302, 32'h0D0C0908, 32'h1312110E, 32'h00181716};
  logic [31:0] exp2 [3] = '{32'h04020100, 32'h09080605, 32'h0E0D0C0A};

  // Monitor on the falling edge: capture output groups, note any valid_out
  // not preceded by a cycle with avail_in=1, and writes made without space.
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      out_q.push_back(bus.data_out);
      if (avail_last !== 1'b1) avail_viol++;
    end
    if (bus.valid_in === 1'b1 && bus.avail_out !== 1'b1) ovf++;
    avail_last = bus.avail_in;
  end

  function automatic logic [31:0] gdata(input int g);
    logic [31:0] d;
    for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(((g % 7) * 4) + k);
    return d;
  endfunction

  task automatic do_configure(input int iters, input int reads, input int ci,
                              input int sk, input int co, input int ni);
    @(posedge clk); #1;
    bus.num_iters          = LMI'(iters);
    bus.num_reads_per_iter = LMR'(reads);
    bus.cols_in            = LMC'(ci);
    bus.col_skip           = LMC'(sk);
    bus.cols_out           = LMC'(co);
    bus.num_items          = (2*LMC)'(ni);
    bus.configure          = 1'b1;
    @(posedge clk); #1;
    bus.configure          = 1'b0;
  endtask

  // Writes n groups whenever avail_out allows, for a fixed number of cycles.
  task automatic stream(input int n, input bit toggle, input int cycles, output int sent);
    sent = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      bus.avail_in = toggle ? ((c % 2) == 0) : 1'b1;
      if (sent < n && bus.avail_out === 1'b1) begin
        bus.valid_in = 1'b1;
        bus.data_in  = gdata(sent);
        sent++;
      end else begin
        bus.valid_in = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    bus.avail_in = 1'b1;
  endtask

  task automatic write_one(input int g);
    @(posedge clk); #1;
    bus.valid_in = 1'b1;
    bus.data_in  = gdata(g);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.configure = 1'b0; bus.valid_in = 1'b0; bus.avail_in = 1'b1;
    bus.data_in = '0; bus.num_iters = '0; bus.num_reads_per_iter = '0;
    bus.cols_in = '0; bus.col_skip = '0; bus.cols_out = '0; bus.num_items = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out); end
    checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.data_out); end
    checks++; if (bus.avail_out !== 1'b1) begin errors++; $display("FAIL reset_avail: got %b expected 1", bus.avail_out); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_fifo_slack();
    out_q.delete();
    write_one(0);
    write_one(1);
    checks++; if (bus.avail_out !== 1'b1) begin errors++; $display("FAIL slack_two: got %b expected 1", bus.avail_out); end
    write_one(2);
    checks++; if (bus.avail_out !== 1'b0) begin errors++; $display("FAIL slack_three: got %b expected 0", bus.avail_out); end
    write_one(3);
    checks++; if (bus.avail_out !== 1'b0) begin errors++; $display("FAIL slack_full: got %b expected 0", bus.avail_out); end
    repeat (5) @(posedge clk);
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL slack_idle_out: got %0d groups expected 0", out_q.size()); end
    pulse_reset();
    #1;
    checks++; if (bus.avail_out !== 1'b1) begin errors++; $display("FAIL slack_reset_avail: got %b expected 1", bus.avail_out); end
  endtask

  task automatic test_basic();
    int sent;
    out_q.delete();
    do_configure(1, 7, 5, 2, 3, 25);
    stream(7, 1'b0, 40, sent);
    checks++; if (sent != 7) begin errors++; $display("FAIL basic_sent: got %0d expected 7", sent); end
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp1[i]) begin errors++; $display("FAIL basic_grp%0d: got %h expected %h", i, out_q[i], exp1[i]); end
    end
    // Back in IDLE nothing is popped, so three writes must close avail_out.
    write_one(0); write_one(1); write_one(2);
    repeat (5) @(posedge clk); #1;
    checks++; if (bus.avail_out !== 1'b0) begin errors++; $display("FAIL basic_idle: got avail_out %b expected 0", bus.avail_out); end
    pulse_reset();
  endtask

  task automatic test_no_flush();
    int sent;
    out_q.delete();
    do_configure(1, 4, 4, 0, 3, 16);
    stream(4, 1'b0, 30, sent);
    checks++; if (sent != 4) begin errors++; $display("FAIL noflush_sent: got %0d expected 4", sent); end
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL noflush_count: got %0d expected 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp2[i]) begin errors++; $display("FAIL noflush_grp%0d: got %h expected %h", i, out_q[i], exp2[i]); end
    end
  endtask

  task automatic test_backpressure();
    int sent;
    out_q.delete();
    avail_viol = 0;
    ovf = 0;
    do_configure(1, 7, 5, 2, 3, 25);
    stream(7, 1'b1, 70, sent);
    checks++; if (sent != 7) begin errors++; $display("FAIL bp_sent: got %0d expected 7", sent); end
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp1[i]) begin errors++; $display("FAIL bp_grp%0d: got %h expected %h", i, out_q[i], exp1[i]); end
    end
    checks++; if (avail_viol != 0) begin errors++; $display("FAIL bp_avail_rule: got %0d violations expected 0", avail_viol); end
    checks++; if (ovf != 0) begin errors++; $display("FAIL bp_overflow: got %0d writes without space expected 0", ovf); end
  endtask

  task automatic test_two_iters();
    int sent;
    out_q.delete();
    do_configure(2, 7, 5, 2, 3, 25);
    stream(14, 1'b0, 70, sent);
    checks++; if (sent != 14) begin errors++; $display("FAIL iter2_sent: got %0d expected 14", sent); end
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL iter2_count: got %0d expected 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp1[i % 4]) begin errors++; $display("FAIL iter2_grp%0d: got %h expected %h", i, out_q[i], exp1[i % 4]); end
    end
  endtask

  task automatic test_mid_reset();
    int sent;
    out_q.delete();
    do_configure(1, 7, 5, 2, 3, 25);
    stream(3, 1'b0, 8, sent);
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 1", out_q.size()); end
    if (out_q.size() > 0) begin
      checks++;
      if (out_q[0] !== exp1[0]) begin errors++; $display("FAIL midrst_pre_grp: got %h expected %h", out_q[0], exp1[0]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.valid_out); end
    checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", bus.data_out); end
    checks++; if (bus.avail_out !== 1'b1) begin errors++; $display("FAIL midrst_avail: got %b expected 1", bus.avail_out); end
    #2;
    rst = 1'b1;
    out_q.delete();
    bus.avail_in = 1'b1;
    repeat (12) @(posedge clk);
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL midrst_quiet: got %0d groups expected 0", out_q.size()); end
    out_q.delete();
    do_configure(1, 7, 5, 2, 3, 25);
    stream(7, 1'b0, 40, sent);
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL midrst_rerun_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp1[i]) begin errors++; $display("FAIL midrst_rerun_grp%0d: got %h expected %h", i, out_q[i], exp1[i]); end
    end
  endtask

  task automatic test_cols_out_zero();
    int sent;
    out_q.delete();
    do_configure(2, 3, 5, 2, 0, 25);
    stream(6, 1'b0, 30, sent);
    checks++; if (sent != 6) begin errors++; $display("FAIL zero_sent: got %0d expected 6", sent); end
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL zero_count: got %0d expected 0", out_q.size()); end
    write_one(0); write_one(1); write_one(2);
    repeat (5) @(posedge clk); #1;
    checks++; if (bus.avail_out !== 1'b0) begin errors++; $display("FAIL zero_idle: got avail_out %b expected 0", bus.avail_out); end
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_fifo_slack();
    test_basic();
    test_no_flush();
    test_backpressure();
    test_two_iters();
    test_mid_reset();
    test_cols_out_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/compact.md
Name: compact

Overview:
- Stage directly downstream of the input-alignment stage.
- Receives groups of GROUP_SIZE items that form row-major rows of cols_in items. Per row it keeps only columns [col_skip, col_skip+cols_out); all other items, and items past num_items, are discarded.
- Kept items are repacked densely into output groups of GROUP_SIZE.
- At the end of each iteration any partial group is flushed, zero-padded.

Parameters:
GROUP_SIZE, 8, items per input/output group
DATA_WIDTH, 8, bits per item
LOG_MAX_ITERS, 16, width of iteration counter
LOG_MAX_READS_PER_ITER, 16, width of reads-per-iteration counter
LOG_MAX_COLS, 16, width of column/item-count config fields

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
configure  in  1  CONFIGURE: load config, start run
num_iters  in  LOG_MAX_ITERS  CONFIGURE: iterations
num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  CONFIGURE: input groups per iteration
cols_in  in  LOG_MAX_COLS  CONFIGURE: items per input row, >= GROUP_SIZE
col_skip  in  LOG_MAX_COLS  CONFIGURE: leading columns dropped per row
cols_out  in  LOG_MAX_COLS  CONFIGURE: columns kept per row, col_skip+cols_out <= cols_in
num_items  in  LOG_MAX_COLS+LOG_MAX_COLS  CONFIGURE: valid input items per iteration; items at or beyond this index are dropped
data_in  in  GROUP_SIZE*DATA_WIDTH  IN: item 0 in LSBs
valid_in  in  1  IN: write strobe
avail_out  out  1  IN: space available
data_out  out  GROUP_SIZE*DATA_WIDTH  OUT: packed group, item 0 in LSBs
valid_out  out  1  OUT: one-cycle strobe per group
avail_in  in  1  OUT: downstream can accept

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE; all counters and buffer count 0.
  - data_out=0, valid_out=0.
  - Input FIFO emptied, so avail_out=1.
  - A reset mid-run discards buffered items and in-flight groups; no output is produced until the next configure.
- Input FIFO: 4 slots.
  - avail_out = ~full & ~almost_full, giving one write of slack after avail_out drops.
  - Writes are accepted in any state, including IDLE.
  - A write while full is lost. This is an upstream protocol violation; the bench flags it.
- configure (sampled while IDLE or RUN):
  - Latches all config fields and sets reads_left=num_reads_per_iter, iters_left=num_iters.
  - Clears col_base, item_idx and buffer count, then goes to RUN.
  - The buffer is cleared even if configure arrives in the same cycle as an op, and the op's results are discarded.
  - num_iters=0 or num_reads_per_iter=0 is illegal.
- Lane tagging, for lane i of the FIFO head:
  - c = col_base+i; if c >= cols_in then c -= cols_in. At most one wrap, because cols_in >= GROUP_SIZE.
  - keep_i = (c >= col_skip) & (c < col_skip+cols_out) & (item_idx+i < num_items).
- RUN op fires when the FIFO is non-empty & avail_in=1. Each op:
  - pops one group;
  - appends kept lanes, in lane order, to the buffer (2*GROUP_SIZE entries) at position count, with count += popcount(keep);
  - advances col_base by GROUP_SIZE mod cols_in and item_idx by GROUP_SIZE;
  - decrements reads_left.
- Output on an op:
  - If the new count >= GROUP_SIZE, the next cycle drives valid_out=1 with buffer[0..GS-1] on data_out; the buffer shifts down by GS and count -= GS.
  - At most one output group per op.
- Latency: 1 cycle from the op cycle to valid_out.
- valid_out is asserted only in response to a cycle where avail_in=1. data_out holds its value when valid_out=0.
- Last op of an iteration (reads_left==1):
  - If the remaining count > 0, go to FLUSH; otherwise go to END.
  - col_base, item_idx and reads_left are reset for the next iteration.
- FLUSH: when avail_in=1, emit the remaining items with zeros in the upper lanes, set count=0, then go to END.
  - If the last op itself emitted a full group, FLUSH emits in a later cycle, so valid_out may be high on consecutive cycles.
- END: if iters_left==1, go to IDLE; else decrement iters_left and return to RUN. END takes 1 cycle with no op.
- Arithmetic:
  - All counters are unsigned.
  - item_idx width is 2*LOG_MAX_COLS and saturates without wrapping.
  - col_base < cols_in always.

Test Plan:
- GS=4, DW=8, cols_in=5, col_skip=2, cols_out=3, num_items=25, reads=7, iters=1, avail_in=1; input items 0..27 with value = index -> 4 groups: {2,3,4,7},{8,9,12,13},{14,17,18,19},{22,23,24,0}; last group via FLUSH; then IDLE.
- Same config with cols_out=3, col_skip=0, cols_in=4, num_items=16, reads=4 -> 3 full groups {0,1,2,4},{5,6,8,9},{10,12,13,14}; no FLUSH.
- Same as test 1 with avail_in toggling 1/0 every cycle and upstream writing whenever avail_out=1 -> identical output sequence; no FIFO overflow; every valid_out follows a cycle with avail_in=1.
- iters=2, test 1 config, 14 input groups -> output sequence of test 1 repeated twice; the flush group of iteration 1 carries no items from iteration 2.
- rst pulsed low mid-run after 3 ops -> valid_out=0 and data_out=0 immediately; avail_out=1; no output until the next configure; a fresh test 1 run then matches exactly.
- cols_out=0 -> no valid_out for the whole run; the FSM still returns to IDLE after num_iters*num_reads_per_iter pops.
